// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache
// sitting in the MEM stage. One 64-bit word per line.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_*_i             MEM-stage access (valid, we, byte addr, wdata, wmask)
//   flush_i             invalidate every line (honoured in IDLE only)
//   rdata_o             load data (hit in IDLE, or fill data in DONE)
//   dcache_ready_o      access-complete pulse
//   mem_block_flag_o    stall request, asserted in the accept cycle of a miss/store
//   bus_*               single-beat memory bus; request held until bus_ack_i
module dcache_wt #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  input  logic        flush_i,
  output logic [63:0] rdata_o,
  output logic        dcache_ready_o,
  output logic        mem_block_flag_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_wmask_o,
  input  logic        bus_ack_i,
  input  logic [63:0] bus_rdata_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 61 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [63:0]        data_q [LINES];

  // latched request; the byte offset is never needed
  logic [63:3]        addr_q;
  logic [63:0]        wdata_q;
  logic [7:0]         wmask_q;
  logic               ld_q;
  logic [63:0]        fill_q;

  logic [IDX_W-1:0]   req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic               req_hit, lat_hit, accept, fill_we, merge_we;
  logic               unused_ok;

  assign req_idx = req_addr_i[3 +: IDX_W];
  assign req_tag = req_addr_i[63 -: TAG_W];
  assign lat_idx = addr_q[3 +: IDX_W];
  assign lat_tag = addr_q[63 -: TAG_W];
  assign unused_ok = ^req_addr_i[2:0];

  // a flush in the same cycle forces the request down the miss path
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_i;
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  assign fill_we  = (state_q == RD_MISS) && bus_ack_i;
  assign merge_we = (state_q == WR_THRU) && bus_ack_i && lat_hit;

  // bus fields come straight from the latch so they stay stable while waiting
  assign bus_we_o    = (state_q == WR_THRU);
  assign bus_addr_o  = {addr_q, 3'b000};
  assign bus_wdata_o = wdata_q;
  assign bus_wmask_o = wmask_q;

  always_comb begin
    state_d          = state_q;
    rdata_o          = '0;
    dcache_ready_o   = 1'b0;
    mem_block_flag_o = 1'b0;
    bus_req_o        = 1'b0;
    accept           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (!req_we_i && req_hit) begin
            dcache_ready_o = 1'b1;
            rdata_o        = data_q[req_idx];
          end else begin
            mem_block_flag_o = 1'b1;
            accept           = 1'b1;
            state_d          = req_we_i ? WR_THRU : RD_MISS;
          end
        end
      end
      RD_MISS, WR_THRU: begin
        bus_req_o = 1'b1;
        if (bus_ack_i) state_d = DONE;
      end
      DONE: begin
        dcache_ready_o = 1'b1;
        rdata_o        = ld_q ? fill_q : 64'd0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      ld_q    <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i[63:3];
        wdata_q <= req_we_i ? req_wdata_i : 64'd0;
        wmask_q <= req_we_i ? req_wmask_i : 8'd0;
        ld_q    <= !req_we_i;
      end
      if (state_q == IDLE && flush_i) valid_q <= '0;
      else if (fill_we)               valid_q[lat_idx] <= 1'b1;
      if (fill_we) fill_q <= bus_rdata_i;
    end
  end

  // tag/data arrays carry no reset; validity is tracked by valid_q alone
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        data_q[lat_idx] <= bus_rdata_i;
        tag_q[lat_idx]  <= lat_tag;
      end else if (merge_we) begin
        for (int b = 0; b < 8; b++)
          if (wmask_q[b]) data_q[lat_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, flush_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic [7:0]  req_wmask_i;
  logic [63:0] rdata_o;
  logic        dcache_ready_o, mem_block_flag_o;
  logic        bus_req_o, bus_we_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_wmask_o;
  logic        bus_ack_i;
  logic [63:0] bus_rdata_i;

  int checks = 0;
  int errors = 0;

  dcache_wt #(.LINES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .dcache_ready_o(dcache_ready_o), .mem_block_flag_o(mem_block_flag_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the accept cycle; returns at posedge+1 of an idle cycle.
  task automatic bus_txn(input string t, input int waits, input logic [63:0] exp_addr,
                         input logic exp_we, input logic [63:0] exp_wd, input logic [7:0] exp_wm,
                         input logic [63:0] fill, input logic [63:0] exp_rd);
    tick();
    req_valid_i = 1'b0; req_we_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      if (i == waits - 1) begin bus_ack_i = 1'b1; bus_rdata_i = fill; end
      mid();
      chk({t, ".bus_req"}, 64'(bus_req_o), 64'd1);
      chk({t, ".bus_addr"}, bus_addr_o, exp_addr);
      chk({t, ".bus_we"}, 64'(bus_we_o), 64'(exp_we));
      if (exp_we) begin
        chk({t, ".bus_wdata"}, bus_wdata_o, exp_wd);
        chk({t, ".bus_wmask"}, 64'(bus_wmask_o), 64'(exp_wm));
      end
      chk({t, ".wait_block"}, 64'(mem_block_flag_o), 64'd0);
      chk({t, ".wait_ready"}, 64'(dcache_ready_o), 64'd0);
      tick();
    end
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    mid();
    chk({t, ".done_ready"}, 64'(dcache_ready_o), 64'd1);
    chk({t, ".done_rdata"}, rdata_o, exp_rd);
    chk({t, ".done_bus_req"}, 64'(bus_req_o), 64'd0);
    tick();
    mid();
    chk({t, ".post_ready"}, 64'(dcache_ready_o), 64'd0);
    tick();
  endtask

  task automatic miss_load(input string t, input logic [63:0] addr, input logic [63:0] fill, input int waits);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
    mid();
    chk({t, ".block"}, 64'(mem_block_flag_o), 64'd1);
    chk({t, ".acc_ready"}, 64'(dcache_ready_o), 64'd0);
    bus_txn(t, waits, {addr[63:3], 3'b000}, 1'b0, 64'd0, 8'd0, fill, fill);
  endtask

  task automatic store(input string t, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] wm, input int waits);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = addr; req_wdata_i = wd; req_wmask_i = wm;
    mid();
    chk({t, ".block"}, 64'(mem_block_flag_o), 64'd1);
    bus_txn(t, waits, {addr[63:3], 3'b000}, 1'b1, wd, wm, 64'h5A5A, 64'd0);
  endtask

  task automatic hit_load(input string t, input logic [63:0] addr, input logic [63:0] exp);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
    mid();
    chk({t, ".ready"}, 64'(dcache_ready_o), 64'd1);
    chk({t, ".rdata"}, rdata_o, exp);
    chk({t, ".block"}, 64'(mem_block_flag_o), 64'd0);
    chk({t, ".bus_req"}, 64'(bus_req_o), 64'd0);
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 0; req_we_i = 0; flush_i = 0;
    req_addr_i = '0; req_wdata_i = '0; req_wmask_i = '0;
    bus_ack_i = 0; bus_rdata_i = '0;
    tick(); tick();
    mid();
    chk("rst.bus_req", 64'(bus_req_o), 64'd0);
    chk("rst.ready", 64'(dcache_ready_o), 64'd0);
    chk("rst.block", 64'(mem_block_flag_o), 64'd0);
    chk("rst.rdata", rdata_o, 64'd0);
    tick();
    rst = 1'b0;

    // cold miss, 3 bus cycles, then same-cycle hit
    miss_load("cold", 64'h1008, 64'hDEADBEEF, 3);
    hit_load("rehit", 64'h1008, 64'hDEADBEEF);

    // write-through store merges byte 0 into the cached line
    store("st_hit", 64'h1008, 64'hFF, 8'h01, 2);
    hit_load("st_merge", 64'h1008, 64'hDEADBEFF);
    store("st_rep", 64'h1008, 64'hFF, 8'h01, 1);
    hit_load("st_idem", 64'h100C, 64'hDEADBEFF);

    // conflict on index 1
    miss_load("conf_b", 64'h1088, 64'h1111, 1);
    hit_load("conf_bhit", 64'h1088, 64'h1111);
    miss_load("conf_a", 64'h1008, 64'hDEADBEFF, 2);

    // store miss does not allocate
    store("st_miss", 64'h2000, 64'h55, 8'hFF, 1);
    miss_load("no_alloc", 64'h2000, 64'h77, 1);

    // reset in the middle of a read miss
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 64'h3010;
    mid();
    chk("rmid.block", 64'(mem_block_flag_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    mid();
    chk("rmid.bus_req", 64'(bus_req_o), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 64'h999;
    mid();
    chk("rmid.post_bus_req", 64'(bus_req_o), 64'd0);
    chk("rmid.post_ready", 64'(dcache_ready_o), 64'd0);
    chk("rmid.post_block", 64'(mem_block_flag_o), 64'd0);
    chk("rmid.post_rdata", rdata_o, 64'd0);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    mid();
    chk("rmid.late_ack_ready", 64'(dcache_ready_o), 64'd0);
    chk("rmid.late_ack_bus_req", 64'(bus_req_o), 64'd0);
    tick();
    miss_load("rmid.same", 64'h3010, 64'h3333, 1);
    miss_load("rmid.inval", 64'h1008, 64'hAAAA, 1);

    // flush with a simultaneous load to a cached address
    miss_load("fl.fill2", 64'h2000, 64'hBBBB, 1);
    hit_load("fl.pre", 64'h2000, 64'hBBBB);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 64'h1008; flush_i = 1'b1;
    mid();
    chk("fl.block", 64'(mem_block_flag_o), 64'd1);
    chk("fl.ready", 64'(dcache_ready_o), 64'd0);
    bus_txn("fl", 1, 64'h1008, 1'b0, 64'd0, 8'd0, 64'hCCCC, 64'hCCCC);
    hit_load("fl.refill", 64'h1008, 64'hCCCC);
    miss_load("fl.other", 64'h2000, 64'hDDDD, 1);
    miss_load("fl.other2", 64'h3010, 64'hEEEE, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
